bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 134 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using double-dabble, one bit per clock.
// Inputs above the largest value representable in DIGITS decimal digits saturate and set ovf_o.
module bin2bcd_seq #(
    parameter int IN_W   = 16,
    parameter int DIGITS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [IN_W-1:0]       data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  ovf_o
);

    localparam int BW    = 4 * DIGITS;
    // Wide enough for both the input and 10^DIGITS - 1 (which is < 16^DIGITS).
    localparam int CW    = ((IN_W > BW) ? IN_W : BW) + 1;
    localparam int CNT_W = $clog2(IN_W + 1);

    function automatic logic [CW-1:0] calc_sat(input int digits);
        logic [CW-1:0] p;
        p = CW'(1);
        for (int i = 0; i < digits; i++) begin
            p = p * CW'(10);
        end
        return p - CW'(1);
    endfunction

    localparam logic [CW-1:0] SAT = calc_sat(DIGITS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BW-1:0]      scratch_q, scratch_d;
    logic [IN_W-1:0]    bin_q, bin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic [BW-1:0]      bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [BW-1:0]      adj;
    logic               sat_hit;

    // If IN_W cannot reach SAT the comparison is constant-false.
    assign sat_hit = (CW'(data_i) > SAT);

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        assign adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5) ?
                                (scratch_q[gi*4 +: 4] + 4'd3) : scratch_q[gi*4 +: 4];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q != S_IDLE);
        done_o = done_q;
        bcd_o  = bcd_q;
        ovf_o  = ovf_q;
    end

    always_comb begin
        scratch_d = scratch_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    bin_d     = sat_hit ? SAT[IN_W-1:0] : data_i;
                    pend_d    = sat_hit;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(IN_W);
                end
            end
            S_SHIFT: begin
                {scratch_d, bin_d} = {adj, bin_q} << 1;
                cnt_d              = cnt_q - CNT_W'(1);
            end
            S_DONE: begin
                bcd_d  = scratch_q;
                ovf_d  = pend_q;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            scratch_q <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            scratch_q <= scratch_d;
            bin_q     <= bin_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: directed corner cases plus random values against an arithmetic
// decimal-conversion reference.
module tb_bin2bcd_seq;

    localparam int IN_W   = 16;
    localparam int DIGITS = 4;
    localparam int LAT    = IN_W + 1;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [15:0] data_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] bcd_o;
    logic        ovf_o;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] exp_bcd  = 16'h0;
    logic        exp_ovf  = 1'b0;

    always #5 clk_i = ~clk_i;

    bin2bcd_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .data_i  (data_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .bcd_o   (bcd_o),
        .ovf_o   (ovf_o)
    );

    function automatic logic [15:0] ref_bcd(input int unsigned v);
        int unsigned s;
        logic [15:0] r;
        s = (v > 9999) ? 9999 : v;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(s % 10);
            s = s / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy_o !== 1'b0 && k < 40) begin
            tick();
            k++;
        end
        check("idle_wait", {31'b0, busy_o}, 32'd0);
    endtask

    task automatic run_conv(input logic [15:0] d, input string tag);
        wait_idle();
        start_i = 1'b1;
        data_i  = d;
        tick();
        start_i = 1'b0;
        data_i  = 16'($urandom);
        for (int k = 0; k < LAT; k++) begin
            check({tag, "_busy"}, {31'b0, busy_o}, 32'd1);
            check({tag, "_nodone"}, {31'b0, done_o}, 32'd0);
            check({tag, "_bcd_hold"}, {16'b0, bcd_o}, {16'b0, exp_bcd});
            check({tag, "_ovf_hold"}, {31'b0, ovf_o}, {31'b0, exp_ovf});
            tick();
        end
        exp_bcd = ref_bcd(d);
        exp_ovf = (d > 16'd9999);
        check({tag, "_done"}, {31'b0, done_o}, 32'd1);
        check({tag, "_idle"}, {31'b0, busy_o}, 32'd0);
        check({tag, "_bcd"}, {16'b0, bcd_o}, {16'b0, exp_bcd});
        check({tag, "_ovf"}, {31'b0, ovf_o}, {31'b0, exp_ovf});
        $display("conv %s: data=%0d bcd=%h ovf=%b (expected %h/%b)", tag, d, bcd_o, ovf_o, exp_bcd, exp_ovf);
        tick();
        check({tag, "_pulse"}, {31'b0, done_o}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i   = 1'b1;
        start_i = 1'b0;
        data_i  = 16'd0;
        #2 rst_i = 1'b0;
        #1;
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_done", {31'b0, done_o}, 32'd0);
        check("rst_bcd", {16'b0, bcd_o}, 32'd0);
        check("rst_ovf", {31'b0, ovf_o}, 32'd0);

        // start_i while held in reset must not be accepted
        start_i = 1'b1;
        data_i  = 16'd77;
        tick();
        tick();
        check("rst_nostart", {31'b0, busy_o}, 32'd0);
        #2 rst_i = 1'b1;
        start_i = 1'b0;
        tick();
        check("rel_idle", {31'b0, busy_o}, 32'd0);

        run_conv(16'd1234, "d1234");
        run_conv(16'd0, "d0");
        run_conv(16'd9999, "d9999");
        run_conv(16'd10000, "d10000");
        run_conv(16'd65535, "d65535");
        run_conv(16'd42, "d42");

        // second start during conversion is ignored and not queued
        wait_idle();
        start_i = 1'b1;
        data_i  = 16'd1111;
        tick();
        start_i = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            if (k == 5) begin
                start_i = 1'b1;
                data_i  = 16'd2222;
            end
            tick();
            if (k == 5) start_i = 1'b0;
            if (k < LAT) check("ign_nodone", {31'b0, done_o}, 32'd0);
        end
        exp_bcd = ref_bcd(1111);
        exp_ovf = 1'b0;
        check("ign_done", {31'b0, done_o}, 32'd1);
        check("ign_bcd", {16'b0, bcd_o}, {16'b0, exp_bcd});
        $display("conv ignore: data=1111 bcd=%h ovf=%b (expected %h/%b)", bcd_o, ovf_o, exp_bcd, exp_ovf);
        tick();
        check("ign_pulse", {31'b0, done_o}, 32'd0);
        check("ign_noqueue", {31'b0, busy_o}, 32'd0);
        tick();
        check("ign_noqueue2", {31'b0, busy_o}, 32'd0);

        // asynchronous reset mid-conversion
        start_i = 1'b1;
        data_i  = 16'd5678;
        tick();
        start_i = 1'b0;
        repeat (7) tick();
        check("abort_busy_pre", {31'b0, busy_o}, 32'd1);
        #2 rst_i = 1'b0;
        #1;
        exp_bcd = 16'h0;
        exp_ovf = 1'b0;
        check("abort_busy", {31'b0, busy_o}, 32'd0);
        check("abort_done", {31'b0, done_o}, 32'd0);
        check("abort_bcd", {16'b0, bcd_o}, 32'd0);
        check("abort_ovf", {31'b0, ovf_o}, 32'd0);
        tick();
        tick();
        check("abort_hold_done", {31'b0, done_o}, 32'd0);
        #2 rst_i = 1'b1;
        for (int k = 0; k < LAT + 2; k++) begin
            tick();
            check("abort_nodone", {31'b0, done_o}, 32'd0);
        end
        $display("conv abort: data=5678 bcd=%h ovf=%b (expected 0000/0)", bcd_o, ovf_o);
        run_conv(16'd321, "d321");

        // back-to-back with start_i held high
        wait_idle();
        start_i = 1'b1;
        data_i  = 16'd7;
        tick();
        data_i  = 16'd8;
        for (int k = 1; k <= LAT + 19; k++) begin
            tick();
            if (k == LAT + 1) start_i = 1'b0;
            if (k == LAT || k == 2 * LAT + 1) begin
                exp_bcd = ref_bcd((k == LAT) ? 7 : 8);
                exp_ovf = 1'b0;
                check("b2b_done", {31'b0, done_o}, 32'd1);
                check("b2b_idle", {31'b0, busy_o}, 32'd0);
                check("b2b_bcd", {16'b0, bcd_o}, {16'b0, exp_bcd});
                $display("conv b2b: k=%0d bcd=%h (expected %h)", k, bcd_o, exp_bcd);
            end else begin
                check("b2b_nodone", {31'b0, done_o}, 32'd0);
            end
        end
        check("b2b_end_idle", {31'b0, busy_o}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            logic [15:0] v;
            if (i % 4 == 0) v = 16'(9990 + $urandom_range(0, 20));
            else            v = 16'($urandom_range(0, 65535));
            run_conv(v, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
